alarm_ctrl: RTL and testbench
=============================

ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter CLK_HZ, 50_000_000, clock frequency in Hz; sets buzzer cadence.
REQ-002 Parameter RING_SEC, 60, seconds of unattended ringing before auto-off.
REQ-003 Parameter SNOOZE_SEC, 300, seconds spent in snooze before re-ringing.
REQ-004 clock  in  1  system clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low.
REQ-006 data_ch  in  24  real-time BCD {H10,H1,M10,M1,S10,S1}, 4 bits per digit.
REQ-007 edit_en  in  1  level; alarm-edit mode selected by top level.
REQ-008 btn_field  in  1  one-cycle pulse; toggle edited field.
REQ-009 btn_inc  in  1  one-cycle pulse; increment edited field.
REQ-010 btn_arm  in  1  one-cycle pulse; toggle armed.
REQ-011 btn_stop  in  1  one-cycle pulse; snooze/cancel.
REQ-012 alarm_data  out  24  alarm time BCD {H10,H1,M10,M1,4'h0,4'h0} for display mux.
REQ-013 field_sel  out  1  0 = hours edited, 1 = minutes edited.
REQ-014 armed  out  1  alarm enabled.
REQ-015 ringing  out  1  high in RING state.
REQ-016 buzzer  out  1  audible drive, 2 Hz square while ringing.

Function
REQ-017 Second event SHALL be data_ch differing from its registered previous value; one event per differing sample.
REQ-018 FSM states SHALL be IDLE, RING, SNOOZE; all outputs registered.
REQ-019 IDLE->RING on the edge sampling a second event with armed=1 and data_ch == {alarm hh, alarm mm, 8'h00}; ringing high the cycle after.
REQ-020 Match SHALL be ignored in RING and SNOOZE.
REQ-021 RING: second counter cleared on entry; after RING_SEC events -> IDLE, armed stays 1.
REQ-022 RING + btn_stop -> SNOOZE, second counter cleared; SNOOZE after SNOOZE_SEC events -> RING.
REQ-023 SNOOZE + btn_stop -> IDLE (alarm cancelled for this day, armed stays 1).
REQ-024 btn_arm toggles armed in any state; disarm forces IDLE next cycle.
REQ-025 btn_arm and btn_stop same cycle: btn_arm wins, btn_stop ignored.
REQ-026 btn_field and btn_inc only act when edit_en=1; ignored otherwise.
REQ-027 Hours increment BCD 00..23, 09->10, 19->20, 23->00; minutes 00..59, 59->00, no carry into hours.
REQ-028 btn_inc and btn_field same cycle: increment applies to old field, then field toggles.
REQ-029 Editing SHALL NOT change FSM state; new alarm time used for next match.
REQ-030 buzzer: high on RING entry, toggles every CLK_HZ/4 cycles while in RING, 0 in other states.
REQ-031 Buzzer divider width SHALL be $clog2(CLK_HZ/4); second counters sized from max(RING_SEC,SNOOZE_SEC).

Reset
REQ-032 reset low: state IDLE, alarm time 07:00 (alarm_data 24'h070000), field_sel 0, armed 0, ringing 0, buzzer 0, counters 0, previous data_ch 24'h000000.
REQ-033 Reset asserted mid-RING or mid-SNOOZE SHALL return all of the above immediately, no output glitch after deassert.

Structure
REQ-034 Shared package chasy_pkg SHALL hold alarm_state_t enum (IDLE, RING, SNOOZE) and BCD digit width constant.
REQ-035 One sub-module alarm_bcd_inc: two-digit BCD increment with wrap limit input (23 or 59), combinational, instantiated once per field.

Verification (bench: CLK_HZ=8, RING_SEC=3, SNOOZE_SEC=2)
REQ-036 Reset, edit_en=1, btn_inc x17 on hours -> alarm_data 24'h000000 after wrap (07+17=24 -> 00).
REQ-037 Alarm 07:00 armed, data_ch 065959 -> 070000 -> ringing=1 next cycle, buzzer 1 for 2 cycles then 0 for 2.
REQ-038 Ringing, no button, three second events -> IDLE, ringing=0, armed=1.
REQ-039 Ringing, btn_stop -> SNOOZE ringing=0; two second events -> ringing=1; btn_stop, btn_stop -> IDLE.
REQ-040 Ringing, btn_arm and btn_stop same cycle -> armed=0, IDLE, buzzer=0 next cycle.
REQ-041 Minutes field 59, btn_inc with btn_field same cycle -> minutes 00, hours unchanged, field_sel=0.

Source files
------------

// File: rtl/chasy_pkg.sv
// Shared types and constants for the clock/alarm blocks.
package chasy_pkg;
  localparam int DIGIT_W = 4;
  localparam int FIELD_W = 2 * DIGIT_W;

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} alarm_state_t;

  localparam logic [FIELD_W-1:0] HOUR_LIMIT  = 8'h23;
  localparam logic [FIELD_W-1:0] MIN_LIMIT   = 8'h59;
  localparam logic [FIELD_W-1:0] ALARM_RST_H = 8'h07;
  localparam logic [FIELD_W-1:0] ALARM_RST_M = 8'h00;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/alarm_bcd_inc.sv
// Two-digit BCD increment that wraps to 00 after reaching limit.
module alarm_bcd_inc
  import chasy_pkg::*;
(
  input  logic [FIELD_W-1:0] val,
  input  logic [FIELD_W-1:0] limit,
  output logic [FIELD_W-1:0] nxt
);
  logic [DIGIT_W-1:0] hi, lo;

  assign hi = val[FIELD_W-1:DIGIT_W];
  assign lo = val[DIGIT_W-1:0];

  always_comb begin
    nxt = val;
    if (val == limit)
      nxt = '0;
    else if (lo == DIGIT_W'(9))
      nxt = {hi + DIGIT_W'(1), DIGIT_W'(0)};
    else
      nxt = {hi, lo + DIGIT_W'(1)};
  end
endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: alarm-time editing, arm/ring/snooze FSM and buzzer cadence.
module alarm_ctrl
  import chasy_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [23:0] data_ch,
  input  logic        edit_en,
  input  logic        btn_field,
  input  logic        btn_inc,
  input  logic        btn_arm,
  input  logic        btn_stop,
  output logic [23:0] alarm_data,
  output logic        field_sel,
  output logic        armed,
  output logic        ringing,
  output logic        buzzer
);
  localparam int QTR     = CLK_HZ / 4;
  localparam int DIV_W   = (QTR > 1) ? $clog2(QTR) : 1;
  localparam int SEC_MAX = max_i(RING_SEC, SNOOZE_SEC);
  localparam int SEC_W   = (SEC_MAX > 1) ? $clog2(SEC_MAX) : 1;

  alarm_state_t       state, state_nxt;
  logic [SEC_W-1:0]   sec_cnt, sec_nxt;
  logic [DIV_W-1:0]   div_cnt, div_nxt;
  logic               buzz_nxt;
  logic [23:0]        prev_data;
  logic [FIELD_W-1:0] alarm_h, alarm_m, inc_h, inc_m;
  logic               sec_evt, match;

  // Any change of the sampled real-time value marks one elapsed second.
  assign sec_evt    = (data_ch != prev_data);
  assign match      = sec_evt && armed && (data_ch == {alarm_h, alarm_m, 8'h00});
  assign alarm_data = {alarm_h, alarm_m, 8'h00};

  alarm_bcd_inc u_inc_h (.val(alarm_h), .limit(HOUR_LIMIT), .nxt(inc_h));
  alarm_bcd_inc u_inc_m (.val(alarm_m), .limit(MIN_LIMIT),  .nxt(inc_m));

  always_comb begin
    state_nxt = state;
    sec_nxt   = sec_cnt;
    div_nxt   = '0;
    buzz_nxt  = 1'b0;

    // Arm button takes priority; stop is ignored in the same cycle.
    if (btn_arm) begin
      if (armed) state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:   if (match) state_nxt = RING;
        RING: begin
          if (btn_stop)
            state_nxt = SNOOZE;
          else if (sec_evt && sec_cnt == SEC_W'(RING_SEC - 1))
            state_nxt = IDLE;
        end
        SNOOZE: begin
          if (btn_stop)
            state_nxt = IDLE;
          else if (sec_evt && sec_cnt == SEC_W'(SNOOZE_SEC - 1))
            state_nxt = RING;
        end
        default: state_nxt = IDLE;
      endcase
    end

    if (state_nxt != state || state_nxt == IDLE)
      sec_nxt = '0;
    else if (sec_evt)
      sec_nxt = sec_cnt + SEC_W'(1);

    // Buzzer starts high on every RING entry, then toggles each quarter second.
    if (state_nxt == RING) begin
      if (state != RING) begin
        buzz_nxt = 1'b1;
      end else if (div_cnt == DIV_W'(QTR - 1)) begin
        buzz_nxt = ~buzzer;
      end else begin
        buzz_nxt = buzzer;
        div_nxt  = div_cnt + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sec_cnt   <= '0;
      div_cnt   <= '0;
      buzzer    <= 1'b0;
      ringing   <= 1'b0;
      prev_data <= '0;
    end else begin
      state     <= state_nxt;
      sec_cnt   <= sec_nxt;
      div_cnt   <= div_nxt;
      buzzer    <= buzz_nxt;
      ringing   <= (state_nxt == RING);
      prev_data <= data_ch;
    end
  end

  // Editing runs independently of the FSM; new time applies to the next match.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      armed     <= 1'b0;
      field_sel <= 1'b0;
      alarm_h   <= ALARM_RST_H;
      alarm_m   <= ALARM_RST_M;
    end else begin
      if (btn_arm) armed <= ~armed;
      if (edit_en) begin
        if (btn_inc) begin
          if (!field_sel) alarm_h <= inc_h;
          else            alarm_m <= inc_m;
        end
        if (btn_field) field_sel <= ~field_sel;
      end
    end
  end
endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed and randomized checks of alarm_ctrl against an arithmetic reference model.
module tb_alarm_ctrl;
  localparam int CLK_HZ     = 8;
  localparam int RING_SEC   = 3;
  localparam int SNOOZE_SEC = 2;
  localparam int QTR        = CLK_HZ / 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [23:0] data_ch = '0;
  logic        edit_en = 1'b0, btn_field = 1'b0, btn_inc = 1'b0;
  logic        btn_arm = 1'b0, btn_stop = 1'b0;
  logic [23:0] alarm_data;
  logic        field_sel, armed, ringing, buzzer;

  int n_chk = 0, n_pass = 0;

  // Model: 0 idle, 1 ring, 2 snooze; times as integers.
  int          m_state, m_hr, m_min, m_secs, m_rcyc;
  bit          m_armed, m_field;
  logic [23:0] m_prev;

  alarm_ctrl #(.CLK_HZ(CLK_HZ), .RING_SEC(RING_SEC), .SNOOZE_SEC(SNOOZE_SEC)) dut (
    .clock(clock), .reset(reset), .data_ch(data_ch), .edit_en(edit_en),
    .btn_field(btn_field), .btn_inc(btn_inc), .btn_arm(btn_arm), .btn_stop(btn_stop),
    .alarm_data(alarm_data), .field_sel(field_sel), .armed(armed),
    .ringing(ringing), .buzzer(buzzer)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [23:0] m_alarm();
    return {bcd(m_hr), bcd(m_min), 8'h00};
  endfunction

  task automatic model_reset();
    m_state = 0; m_hr = 7; m_min = 0; m_secs = 0; m_rcyc = 0;
    m_armed = 0; m_field = 0; m_prev = '0;
  endtask

  task automatic model_step();
    bit evt;
    logic [23:0] tgt;
    evt    = (data_ch != m_prev);
    tgt    = m_alarm();
    m_prev = data_ch;
    if (btn_arm) begin
      if (m_armed) m_state = 0;
      m_armed = !m_armed;
    end else begin
      case (m_state)
        0: if (evt && m_armed && data_ch == tgt) begin
             m_state = 1; m_secs = 0; m_rcyc = 0;
           end
        1: if (btn_stop) begin
             m_state = 2; m_secs = 0;
           end else begin
             if (evt) m_secs++;
             if (m_secs == RING_SEC) m_state = 0;
             else m_rcyc++;
           end
        default: if (btn_stop) begin
             m_state = 0;
           end else if (evt) begin
             m_secs++;
             if (m_secs == SNOOZE_SEC) begin
               m_state = 1; m_secs = 0; m_rcyc = 0;
             end
           end
      endcase
    end
    if (edit_en) begin
      if (btn_inc) begin
        if (!m_field) m_hr = (m_hr + 1) % 24;
        else          m_min = (m_min + 1) % 60;
      end
      if (btn_field) m_field = !m_field;
    end
  endtask

  task automatic check_all(input string tag);
    bit exp_buzz;
    exp_buzz = (m_state == 1) && (((m_rcyc / QTR) % 2) == 0);
    chk({tag, ".alarm"},   32'(alarm_data), 32'(m_alarm()));
    chk({tag, ".field"},   32'(field_sel),  32'(m_field));
    chk({tag, ".armed"},   32'(armed),      32'(m_armed));
    chk({tag, ".ringing"}, 32'(ringing),    32'(m_state == 1));
    chk({tag, ".buzzer"},  32'(buzzer),     32'(exp_buzz));
  endtask

  task automatic step(input string tag, input logic [23:0] d, input bit e, input bit f,
                      input bit i, input bit a, input bit s);
    data_ch = d; edit_en = e; btn_field = f; btn_inc = i; btn_arm = a; btn_stop = s;
    @(posedge clock);
    model_step();
    #1;
    check_all(tag);
    btn_field = 0; btn_inc = 0; btn_arm = 0; btn_stop = 0;
  endtask

  task automatic async_reset(input string tag);
    @(negedge clock);
    #2 reset = 0;
    #1;
    model_reset();
    check_all(tag);
    chk({tag, ".rstval"}, 32'(alarm_data), 32'h070000);
    @(negedge clock);
    reset = 1;
  endtask

  initial begin
    model_reset();
    #12;
    check_all("por");
    chk("por.ringing", 32'(ringing), 32'h0);
    @(negedge clock);
    reset = 1;

    // Hour wrap: 07 + 17 increments -> 00.
    repeat (17) step("hr_inc", 24'h0, 1, 0, 1, 0, 0);
    chk("hr_wrap", 32'(alarm_data), 32'h000000);
    async_reset("rst1");

    // Arm and ring at 07:00; buzzer two cycles high, two low.
    step("arm", 24'h0, 0, 0, 0, 1, 0);
    step("pre", 24'h065959, 0, 0, 0, 0, 0);
    chk("pre.ringing", 32'(ringing), 32'h0);
    step("hit", 24'h070000, 0, 0, 0, 0, 0);
    chk("hit.ringing", 32'(ringing), 32'h1);
    chk("buz0", 32'(buzzer), 32'h1);
    step("b1", 24'h070000, 0, 0, 0, 0, 0); chk("buz1", 32'(buzzer), 32'h1);
    step("b2", 24'h070000, 0, 0, 0, 0, 0); chk("buz2", 32'(buzzer), 32'h0);
    step("b3", 24'h070000, 0, 0, 0, 0, 0); chk("buz3", 32'(buzzer), 32'h0);
    step("b4", 24'h070000, 0, 0, 0, 0, 0); chk("buz4", 32'(buzzer), 32'h1);

    // Unattended ringing auto-off after three seconds.
    step("s1", 24'h070001, 0, 0, 0, 0, 0);
    step("s2", 24'h070002, 0, 0, 0, 0, 0);
    chk("s2.ringing", 32'(ringing), 32'h1);
    step("s3", 24'h070003, 0, 0, 0, 0, 0);
    chk("auto_off.ringing", 32'(ringing), 32'h0);
    chk("auto_off.armed", 32'(armed), 32'h1);

    // Snooze, re-ring, then cancel.
    step("ring2", 24'h070000, 0, 0, 0, 0, 0);
    step("snz", 24'h070000, 0, 0, 0, 0, 1);
    chk("snz.ringing", 32'(ringing), 32'h0);
    step("z1", 24'h070001, 0, 0, 0, 0, 0);
    step("z2", 24'h070002, 0, 0, 0, 0, 0);
    chk("rering", 32'(ringing), 32'h1);
    step("stop1", 24'h070002, 0, 0, 0, 0, 1);
    step("stop2", 24'h070002, 0, 0, 0, 0, 1);
    step("idle1", 24'h070003, 0, 0, 0, 0, 0);
    step("idle2", 24'h070004, 0, 0, 0, 0, 0);
    chk("cancel.ringing", 32'(ringing), 32'h0);

    // Arm and stop together: disarm wins.
    step("ring3", 24'h070000, 0, 0, 0, 0, 0);
    step("armstop", 24'h070000, 0, 0, 0, 1, 1);
    chk("armstop.armed", 32'(armed), 32'h0);
    chk("armstop.buzzer", 32'(buzzer), 32'h0);
    step("dis1", 24'h070001, 0, 0, 0, 0, 0);
    step("dis2", 24'h070000, 0, 0, 0, 0, 0);

    // Reset in the middle of RING and of SNOOZE.
    step("rearm", 24'h070001, 0, 0, 0, 1, 0);
    step("ring4", 24'h070000, 0, 0, 0, 0, 0);
    async_reset("rst_ring");
    step("post1", 24'h070000, 0, 0, 0, 0, 0);
    step("rearm2", 24'h070001, 0, 0, 0, 1, 0);
    step("ring5", 24'h070000, 0, 0, 0, 0, 0);
    step("snz2", 24'h070000, 0, 0, 0, 0, 1);
    async_reset("rst_snz");
    step("post2", 24'h070000, 0, 0, 0, 0, 0);

    // Minutes 59 with inc+field: minutes wrap, hours kept, field back to hours.
    step("fld", 24'h070000, 1, 1, 0, 0, 0);
    repeat (59) step("min_inc", 24'h070000, 1, 0, 1, 0, 0);
    chk("min59", 32'(alarm_data), 32'h075900);
    step("incfld", 24'h070000, 1, 1, 1, 0, 0);
    chk("min_wrap", 32'(alarm_data), 32'h070000);
    chk("min_wrap.field", 32'(field_sel), 32'h0);
    step("noedit", 24'h070000, 0, 1, 1, 0, 0);

    // Randomized traffic.
    step("rarm", 24'h070000, 0, 0, 0, 1, 0);
    for (int n = 0; n < 3000; n++) begin
      logic [23:0] d;
      int r;
      bit e;
      r = $urandom_range(0, 9);
      if (r < 4)      d = data_ch;
      else if (r < 7) d = data_ch + 24'($urandom_range(1, 3));
      else if (r < 9) d = m_alarm();
      else            d = 24'($urandom);
      e = ($urandom_range(0, 3) == 0) ? !edit_en : edit_en;
      step("rand", d, e, $urandom_range(0, 14) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
